// File: rtl/pipelined_shifter.sv
// pipelined_shifter
//   Logarithmic barrel shifter with one register stage per shift-amount bit.
//   Stage s shifts or rotates by 2^s when ShiftVal[s] is set. A single global
//   hold (output valid but not accepted) freezes every stage, bubbles included,
//   so ordering and count of commands are always preserved.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   InValid/InReady   command handshake (ShiftIn, ShiftVal, Mode)
//   ShiftIn           operand, WIDTH bits
//   ShiftVal          shift amount, SHW bits
//   Mode              0 = sll, 1 = sra, 2 = ror, 3 = srl
//   OutValid/OutReady result handshake (ShiftOut, Zero)
//   ShiftOut          result, driven straight from the last stage register
//   Zero              ShiftOut == 0, qualified by OutValid
module pipelined_shifter #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] ShiftIn,
  input  logic [SHW-1:0]   ShiftVal,
  input  logic [1:0]       Mode,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ShiftOut,
  output logic             Zero
);

  localparam logic [1:0] ModeSll = 2'd0;
  localparam logic [1:0] ModeSra = 2'd1;
  localparam logic [1:0] ModeRor = 2'd2;
  localparam logic [1:0] ModeSrl = 2'd3;

  // Registered stage outputs. Mode and shift amount are only needed by the
  // stages that follow, so the last stage keeps data and valid only.
  logic [WIDTH-1:0] dataQ [SHW];
  logic [SHW-1:0]   vldQ;
  logic [1:0]       modeQ [SHW-1];
  logic [SHW-1:0]   shvQ  [SHW-1];

  // Per-stage inputs: stage 0 sees the ports, stage s sees register s-1.
  logic [WIDTH-1:0] stData [SHW];
  logic [1:0]       stMode [SHW];
  logic [SHW-1:0]   stShv  [SHW];
  logic [SHW-1:0]   stVld;
  logic [WIDTH-1:0] stOut  [SHW];

  logic stall;

  function automatic logic [WIDTH-1:0] shiftStep(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input int               k
  );
    logic [WIDTH-1:0] r;
    case (m)
      ModeSll: r = d << k;
      // Arithmetic fill with the current MSB; since every stage preserves the
      // sign, the cascade equals one arithmetic shift by the full amount.
      ModeSra: r = $signed(d) >>> k;
      ModeRor: r = (d >> k) | (d << (WIDTH - k));
      ModeSrl: r = d >> k;
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    stData[0] = ShiftIn;
    stMode[0] = Mode;
    stShv[0]  = ShiftVal;
    stVld[0]  = InValid;
    for (int s = 1; s < SHW; s++) begin
      stData[s] = dataQ[s-1];
      stMode[s] = modeQ[s-1];
      stShv[s]  = shvQ[s-1];
      stVld[s]  = vldQ[s-1];
    end
  end

  always_comb begin
    for (int s = 0; s < SHW; s++) begin
      stOut[s] = stShv[s][s] ? shiftStep(stData[s], stMode[s], 1 << s) : stData[s];
    end
  end

  assign stall   = vldQ[SHW-1] & ~OutReady;
  assign InReady = ~stall;

  // Stage 0 loads only when not stalled, and then InReady is 1, so capturing
  // InValid here is exactly the accept condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vldQ <= '0;
      for (int s = 0; s < SHW; s++) begin
        dataQ[s] <= '0;
      end
      for (int s = 0; s < SHW - 1; s++) begin
        modeQ[s] <= '0;
        shvQ[s]  <= '0;
      end
    end else if (!stall) begin
      vldQ <= stVld;
      for (int s = 0; s < SHW; s++) begin
        dataQ[s] <= stOut[s];
      end
      for (int s = 0; s < SHW - 1; s++) begin
        modeQ[s] <= stMode[s];
        shvQ[s]  <= stShv[s];
      end
    end
  end

  assign OutValid = vldQ[SHW-1];
  assign ShiftOut = dataQ[SHW-1];
  // Gated by valid so Zero reads 0 out of reset even though the data is 0.
  assign Zero     = vldQ[SHW-1] & (dataQ[SHW-1] == '0);

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the 16-bit combinational Shifter.
- Performs a logarithmic barrel shift with one register stage per shift-amount bit. Modes: sll, sra, ror, plus a new srl mode.
- Uses valid/ready handshakes on input and output, with full backpressure and an output Zero flag.
- Sits between the ALU operand mux and the EX/MEM result path on designs needing wider datapaths or higher clock rates.

Parameters:
- WIDTH, 16, data width in bits; must be a power of two, 4..64.
- SHW, $clog2(WIDTH), width of ShiftVal and number of pipeline stages; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- InValid  input  1  operand/command valid.
- InReady  output  1  pipeline can accept a command this cycle.
- ShiftIn  input  WIDTH  operand.
- ShiftVal  input  SHW  shift amount, 0..WIDTH-1.
- Mode  input  2  operation: 0 = sll, 1 = sra, 2 = ror, 3 = srl.
- OutValid  output  1  ShiftOut/Zero hold a valid result.
- OutReady  input  1  consumer accepts result this cycle.
- ShiftOut  output  WIDTH  result.
- Zero  output  1  ShiftOut == 0; valid only when OutValid = 1.

Behaviour:
- Reset: rst high clears every stage valid bit immediately (async), independent of clk.
  - OutValid = 0, ShiftOut = 0, Zero = 0; InReady = 1 once rst is low.
  - Stage data and Mode registers also clear to 0.
  - In-flight commands are discarded, not completed.
- Pipeline structure:
  - Stage s (s = 0..SHW-1) applies a shift/rotate of 2^s if ShiftVal[s] = 1, otherwise passes data through. The result is registered.
  - Each stage carries data, remaining ShiftVal bits, Mode and a valid bit.
  - The final stage register drives ShiftOut/Zero directly, so outputs are combinationally independent of inputs.
- Accept: a transfer occurs on an edge where InValid & InReady = 1.
- Latency: an accepted command produces OutValid = 1 exactly SHW cycles later if unstalled (WIDTH = 16 gives 4 cycles).
- Throughput: one command per cycle.
- Stall rule:
  - stall = OutValid & ~OutReady; InReady = ~stall.
  - While stalled, all stages hold their contents, including bubbles.
  - No command is dropped, duplicated or reordered.
- Output completion:
  - A result leaves on an edge with OutValid & OutReady.
  - If no new result arrives from stage SHW-2 on that edge, OutValid falls the next cycle.
  - Simultaneous output-accept and input-accept is legal at full rate.
- Arithmetic/width rules per stage, shift k = 2^s:
  - sll: data << k, zero fill.
  - srl: data >> k, zero fill.
  - sra: data >> k, filled with the current MSB; the sign is preserved through stages, so this equals $signed(ShiftIn) >>> ShiftVal.
  - ror: {data[k-1:0], data[WIDTH-1:k]}.
- ShiftVal = 0 in any mode gives ShiftOut = ShiftIn.
- Boundary cases:
  - ShiftVal = WIDTH-1: sll leaves only bit 0 at the MSB; sra yields all-sign; ror equals rotate-left by 1.
  - Bubbles (InValid = 0) propagate as valid = 0; data contents are don't-care but must not raise OutValid.
- Zero is computed from the final-stage register, not from a separate pipeline.

Test Plan:
- WIDTH = 16, unstalled, OutReady = 1; issue ShiftIn = 0xAB00, ShiftVal = 4 in Mode 0/1/2/3 on consecutive cycles → OutValid on cycles 4..7 with ShiftOut = 0xB000, 0xFAB0, 0x0AB0, 0x0AB0; Zero = 0.
- Boundaries, ShiftIn = 0xAB00:
  - sll by 8 → 0x0000, Zero = 1.
  - sra by 15 → 0xFFFF.
  - srl by 15 → 0x0001.
  - ror by 0 → 0xAB00.
  - ror by 15 → 0x5601.
- Backpressure: issue 6 back-to-back commands and hold OutReady = 0 for 3 cycles after first OutValid.
  - InReady must be 0 while stalled.
  - All 6 results emerge in order, each exactly once, matching the reference model.
- Bubbles: alternate InValid 1/0 for 8 cycles → OutValid alternates with the same pattern delayed by 4 cycles.
- Reset mid-operation: assert rst asynchronously, between edges, with 3 commands in flight.
  - OutValid drops immediately.
  - After release, nothing from before reset appears.
  - A new command returns correctly after 4 cycles.
- WIDTH = 8 instance: exhaustive random sweep of all ShiftIn, all ShiftVal 0..7 and all 4 modes with random OutReady → every result matches the reference model; latency is 3 when unstalled.
